// File: rtl/data_mem_responder_if.sv
// Memory-stage <-> data RAM load/store bus.
// resp_err exists only when DMEM_RANGE_CHECK_EN is defined.
interface data_mem_responder_if #(
    parameter int DATA_WIDTH = 16
);
    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    // The initiator holds request fields only in that cycle. Exactly one
    // resp_valid pulse follows each accepted request. No backpressure exists on
    // the response. stall is asserted for the whole time the stage must freeze.
    logic                  req_valid;
    logic                  req_we;
    logic [15:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  stall;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
`ifdef DMEM_RANGE_CHECK_EN
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, stall, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, stall, resp_valid, resp_rdata, resp_err
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, stall, resp_valid, resp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, stall, resp_valid, resp_rdata
    );
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Data RAM responder: one outstanding load/store, fixed LATENCY, stall to pipeline.
// Optional macro DMEM_RANGE_CHECK_EN flags accesses with nonzero upper address bits.
module data_mem_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic [1:0]           state_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    oor_q;
    logic                    resp_valid_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q;
    logic                    resp_err_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    capture;
    logic                    access;
    logic                    acc_we;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic                    acc_oor;
    logic                    req_oor;

`ifdef DMEM_RANGE_CHECK_EN
    assign req_oor = |(bus.req_addr >> ADDR_WIDTH);
`else
    assign req_oor = 1'b0;
`endif

    // With LATENCY == 1 the access happens on the accepting edge, so use the live request.
    always_comb begin
        acc_we    = we_q;
        acc_idx   = addr_q;
        acc_wdata = wdata_q;
        acc_oor   = oor_q;
        if (state_q == IDLE) begin
            acc_we    = bus.req_we;
            acc_idx   = bus.req_addr[ADDR_WIDTH-1:0];
            acc_wdata = bus.req_wdata;
            acc_oor   = req_oor;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        cnt_d   = 4'(LATENCY - 2);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            oor_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= access;
            resp_err_q   <= access & acc_oor;
            if (capture) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr[ADDR_WIDTH-1:0];
                wdata_q <= bus.req_wdata;
                oor_q   <= req_oor;
            end
            if (access) begin
                if (acc_we || acc_oor) begin
                    resp_rdata_q <= '0;
                end else begin
                    resp_rdata_q <= mem_q[acc_idx];
                end
            end
        end
    end

    // RAM has no reset; a store caught by reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && access && acc_we && !acc_oor) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.stall      = (state_q == WAIT) || ((state_q == IDLE) && bus.req_valid);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
`ifdef DMEM_RANGE_CHECK_EN
    assign bus.resp_err   = resp_err_q;
`endif
    assign state_o        = state_q;

endmodule
